// File: rtl/fft_analyzer.sv
// fft_analyzer: N-point radix-2 DIT FFT with bit-reversed streaming load, in-place butterflies and handshaken bins.
// Optional feature macro FFT_PEAK_DETECT_EN builds the |re|+|im| peak tracker behind peak_bin.
module fft_analyzer #(
  parameter  int N    = 16,
  parameter  int DW   = 16,
  localparam int LOGN = $clog2(N),
  localparam int OW   = DW + LOGN + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOGN-1:0]      out_idx,
  output logic signed [OW-1:0] out_re,
  output logic signed [OW-1:0] out_im,
  output logic                 done,
  output logic [LOGN-1:0]      peak_bin,
  output logic                 busy
);

  localparam int SW = $clog2(LOGN);
  localparam int BW = LOGN - 1;
  localparam int PW = OW + 17;
  localparam logic [BW-1:0]        BFLY_LAST  = BW'(N/2 - 1);
  localparam logic [SW-1:0]        STAGE_LAST = SW'(LOGN - 1);
  localparam logic [LOGN-1:0]      IDX_LAST   = LOGN'(N - 1);
  localparam logic signed [PW-1:0] RND        = PW'(32'sd8192);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t                state_r;
  logic [LOGN-1:0]       cnt_r;
  logic [SW-1:0]         stage_r;
  logic [BW-1:0]         bfly_r;
  logic signed [OW-1:0]  re_mem_r [N];
  logic signed [OW-1:0]  im_mem_r [N];

  logic [LOGN-1:0]       b_s, mask_s, j_s, p_s, q_s;
  logic [3:0]            tw_idx_s;
  logic [31:0]           tw_s;
  logic signed [OW-1:0]  a_re_s, a_im_s, b_re_s, b_im_s;
  logic signed [PW-1:0]  wr_x_s, wi_x_s, br_x_s, bi_x_s, prod_re_s, prod_im_s;
  logic signed [OW-1:0]  t_re_s, t_im_s;
  logic signed [OW-1:0]  xp_re_s, xp_im_s, xq_re_s, xq_im_s;
  logic                  hs_s, last_bin_s;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    r = '0;
    for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
    return r;
  endfunction

  // W32^k packed as {cos, -sin} in Q2.14.
  function automatic logic [31:0] twiddle(input logic [3:0] k);
    logic [31:0] w;
    case (k)
      4'd0:    w = {16'sd16384,   16'sd0};
      4'd1:    w = {16'sd16069,  -16'sd3196};
      4'd2:    w = {16'sd15137,  -16'sd6270};
      4'd3:    w = {16'sd13623,  -16'sd9102};
      4'd4:    w = {16'sd11585,  -16'sd11585};
      4'd5:    w = {16'sd9102,   -16'sd13623};
      4'd6:    w = {16'sd6270,   -16'sd15137};
      4'd7:    w = {16'sd3196,   -16'sd16069};
      4'd8:    w = {16'sd0,      -16'sd16384};
      4'd9:    w = {-16'sd3196,  -16'sd16069};
      4'd10:   w = {-16'sd6270,  -16'sd15137};
      4'd11:   w = {-16'sd9102,  -16'sd13623};
      4'd12:   w = {-16'sd11585, -16'sd11585};
      4'd13:   w = {-16'sd13623, -16'sd9102};
      4'd14:   w = {-16'sd15137, -16'sd6270};
      4'd15:   w = {-16'sd16069, -16'sd3196};
      default: w = {16'sd16384,   16'sd0};
    endcase
    return w;
  endfunction

  // Butterfly address generation, twiddle lookup and the rounded complex product.
  always_comb begin
    b_s       = {1'b0, bfly_r};
    mask_s    = (LOGN'(1'b1) << stage_r) - LOGN'(1'b1);
    j_s       = b_s & mask_s;
    p_s       = ((b_s & ~mask_s) << 1'b1) | j_s;
    q_s       = p_s | (LOGN'(1'b1) << stage_r);
    tw_idx_s  = 4'(j_s) << (32'd4 - 32'(stage_r));
    tw_s      = twiddle(tw_idx_s);
    a_re_s    = re_mem_r[p_s];
    a_im_s    = im_mem_r[p_s];
    b_re_s    = re_mem_r[q_s];
    b_im_s    = im_mem_r[q_s];
    wr_x_s    = {{(PW-16){tw_s[31]}}, tw_s[31:16]};
    wi_x_s    = {{(PW-16){tw_s[15]}}, tw_s[15:0]};
    br_x_s    = {{(PW-OW){b_re_s[OW-1]}}, b_re_s};
    bi_x_s    = {{(PW-OW){b_im_s[OW-1]}}, b_im_s};
    prod_re_s = wr_x_s * br_x_s - wi_x_s * bi_x_s + RND;
    prod_im_s = wr_x_s * bi_x_s + wi_x_s * br_x_s + RND;
    // Taking bits [OW+13:14] is the arithmetic shift by 14 followed by truncation to OW.
    t_re_s    = prod_re_s[OW+13:14];
    t_im_s    = prod_im_s[OW+13:14];
    xp_re_s   = a_re_s + t_re_s;
    xp_im_s   = a_im_s + t_im_s;
    xq_re_s   = a_re_s - t_re_s;
    xq_im_s   = a_im_s - t_im_s;
    hs_s       = (state_r == OUTPUT) && out_ready;
    last_bin_s = (out_idx == IDX_LAST);
  end

  // Frame sequencer: sample load, one butterfly per cycle, bin streaming and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= LOAD;
      cnt_r     <= '0;
      stage_r   <= '0;
      bfly_r    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_re    <= '0;
      out_im    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          done <= 1'b0;
          if (in_valid) begin
            re_mem_r[bitrev(cnt_r)] <= {{(OW-DW){in_data[DW-1]}}, in_data};
            im_mem_r[bitrev(cnt_r)] <= '0;
            cnt_r <= cnt_r + LOGN'(1'b1);
            if (cnt_r == IDX_LAST) begin
              state_r  <= COMPUTE;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          re_mem_r[p_s] <= xp_re_s;
          im_mem_r[p_s] <= xp_im_s;
          re_mem_r[q_s] <= xq_re_s;
          im_mem_r[q_s] <= xq_im_s;
          if (bfly_r == BFLY_LAST) begin
            bfly_r <= '0;
            if (stage_r == STAGE_LAST) begin
              // Bin 0 was last written at the start of the final stage, so it is already settled.
              stage_r   <= '0;
              state_r   <= OUTPUT;
              out_valid <= 1'b1;
              out_idx   <= '0;
              out_re    <= re_mem_r[0];
              out_im    <= im_mem_r[0];
            end else begin
              stage_r <= stage_r + SW'(1'b1);
            end
          end else begin
            bfly_r <= bfly_r + BW'(1'b1);
          end
        end
        OUTPUT: begin
          if (hs_s) begin
            if (last_bin_s) begin
              state_r   <= FINISH;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx <= out_idx + LOGN'(1'b1);
              out_re  <= re_mem_r[out_idx + LOGN'(1'b1)];
              out_im  <= im_mem_r[out_idx + LOGN'(1'b1)];
            end
          end
        end
        FINISH: begin
          state_r  <= LOAD;
          done     <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: begin
          state_r   <= LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef FFT_PEAK_DETECT_EN
  logic [OW-1:0]   abs_re_s, abs_im_s;
  logic [OW:0]     mag_s, best_mag_r;
  logic [LOGN-1:0] best_idx_r, peak_r;
  logic            in_band_s;

  // L1 magnitude of the bin currently presented.
  always_comb begin
    if (out_re[OW-1]) abs_re_s = -out_re;
    else              abs_re_s = out_re;
    if (out_im[OW-1]) abs_im_s = -out_im;
    else              abs_im_s = out_im;
    mag_s     = {1'b0, abs_re_s} + {1'b0, abs_im_s};
    in_band_s = (out_idx != '0) && (out_idx <= LOGN'(N/2));
  end

  // Strict running maximum over bins 1..N/2; bin 1 restarts it so ties keep the lowest index.
  always_ff @(posedge clk) begin
    if (rst) begin
      best_mag_r <= '0;
      best_idx_r <= '0;
      peak_r     <= '0;
    end else begin
      if (hs_s && in_band_s && ((out_idx == LOGN'(1'b1)) || (mag_s > best_mag_r))) begin
        best_mag_r <= mag_s;
        best_idx_r <= out_idx;
      end
      if (hs_s && last_bin_s) peak_r <= best_idx_r;
    end
  end

  assign peak_bin = peak_r;
`else
  assign peak_bin = {LOGN{1'b0}};
`endif

endmodule

// File: tb/tb_fft_analyzer.sv
// Self-checking bench for fft_analyzer: N=16 and N=8 instances against a loop-level FFT reference model.
module tb_fft_analyzer;
  localparam int  DW = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, out_ready, sel8;
  logic signed [DW-1:0] in_data;
  logic iv16, iv8;
  assign iv16 = in_valid & ~sel8;
  assign iv8  = in_valid & sel8;

  logic ir16, ov16, dn16, bz16;
  logic [3:0] idx16, pk16;
  logic signed [20:0] re16, im16;
  logic ir8, ov8, dn8, bz8;
  logic [2:0] idx8, pk8;
  logic signed [19:0] re8, im8;

  fft_analyzer #(.N(16), .DW(DW)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_data(in_data), .in_ready(ir16),
    .out_valid(ov16), .out_ready(out_ready), .out_idx(idx16), .out_re(re16), .out_im(im16),
    .done(dn16), .peak_bin(pk16), .busy(bz16));

  fft_analyzer #(.N(8), .DW(DW)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_data(in_data), .in_ready(ir8),
    .out_valid(ov8), .out_ready(out_ready), .out_idx(idx8), .out_re(re8), .out_im(im8),
    .done(dn8), .peak_bin(pk8), .busy(bz8));

  logic c_ir, c_ov, c_dn, c_bz;
  logic [3:0] c_idx, c_pk;
  logic signed [20:0] c_re, c_im;
  assign c_ir  = sel8 ? ir8 : ir16;
  assign c_ov  = sel8 ? ov8 : ov16;
  assign c_dn  = sel8 ? dn8 : dn16;
  assign c_bz  = sel8 ? bz8 : bz16;
  assign c_idx = sel8 ? {1'b0, idx8} : idx16;
  assign c_pk  = sel8 ? {1'b0, pk8} : pk16;
  assign c_re  = sel8 ? {re8[19], re8} : re16;
  assign c_im  = sel8 ? {im8[19], im8} : im16;

  int checks = 0, passes = 0, fails = 0;
  int x [32];
  longint mre [32], mim [32], gre [32], gim [32];
  int mpk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    checks++;
    assert (obs >= lo && obs <= hi) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic longint rnd(input real v);
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else          return -longint'($rtoi(-v + 0.5));
  endfunction

  function automatic longint wrap(input longint v, input int w);
    longint one, m;
    one = 1;
    m = v & ((one << w) - one);
    if (((m >> (w - 1)) & one) != 0) m = m - (one << w);
    return m;
  endfunction

  function automatic int brev(input int i, input int lg);
    int r;
    r = 0;
    for (int b = 0; b < lg; b++) if (((i >> b) & 1) != 0) r = r | (1 << (lg - 1 - b));
    return r;
  endfunction

  // Reference: in-place DIT FFT over stage/group/offset loops with the fixed-point rounding rules.
  task automatic model(input int n);
    longint are [32], aim [32];
    longint wr, wi, tre, tim, pr, pim, best, mag;
    int lg, ow, h, p, q, k32;
    lg = $clog2(n);
    ow = DW + lg + 1;
    for (int i = 0; i < n; i++) begin
      are[brev(i, lg)] = x[i];
      aim[brev(i, lg)] = 0;
    end
    for (int s = 0; s < lg; s++) begin
      h = 1 << s;
      for (int g = 0; g < n / (2 * h); g++) begin
        for (int j = 0; j < h; j++) begin
          p   = g * 2 * h + j;
          q   = p + h;
          k32 = (j * n / (2 * h)) * (32 / n);
          wr  = rnd(16384.0 * $cos(2.0 * PI * k32 / 32.0));
          wi  = -rnd(16384.0 * $sin(2.0 * PI * k32 / 32.0));
          tre = wrap(((wr * are[q] - wi * aim[q]) + 8192) >>> 14, ow);
          tim = wrap(((wr * aim[q] + wi * are[q]) + 8192) >>> 14, ow);
          pr  = are[p];
          pim = aim[p];
          are[p] = wrap(pr + tre, ow);
          aim[p] = wrap(pim + tim, ow);
          are[q] = wrap(pr - tre, ow);
          aim[q] = wrap(pim - tim, ow);
        end
      end
    end
    best = -1;
    mpk  = 0;
    for (int k = 0; k < n; k++) begin
      mre[k] = are[k];
      mim[k] = aim[k];
      if (k >= 1 && k <= n / 2) begin
        mag = (are[k] < 0 ? -are[k] : are[k]) + (aim[k] < 0 ? -aim[k] : aim[k]);
        if (mag > best) begin
          best = mag;
          mpk  = k;
        end
      end
    end
`ifndef FFT_PEAK_DETECT_EN
    mpk = 0;
`endif
  endtask

  task automatic load_frame(input int n, input string tag);
    sel8 = (n == 8);
    @(negedge clk);
    chk($sformatf("%s/in_ready_load", tag), c_ir, 1);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(x[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk($sformatf("%s/busy_compute", tag), c_bz, 1);
    chk($sformatf("%s/in_ready_compute", tag), c_ir, 0);
  endtask

  task automatic finish_frame(input int n, input string tag, input int stall_idx, input bit rnd_stall);
    int cyc, hs, stalls, guard;
    bit held, stall;
    logic [3:0] h_idx;
    logic signed [20:0] h_re, h_im;
    cyc = 0;
    while (!c_ov && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("%s/compute_cycles", tag), cyc, $clog2(n) * n / 2);
    hs = 0; stalls = 0; guard = 0; held = 1'b0;
    while (hs < n && guard < 2000) begin
      guard++;
      if (held) begin
        chk($sformatf("%s/hold_idx", tag), c_idx, h_idx);
        chk($sformatf("%s/hold_re", tag), c_re, h_re);
        chk($sformatf("%s/hold_im", tag), c_im, h_im);
      end
      if (c_ov) begin
        stall = (c_idx == stall_idx && stalls < 5) || (rnd_stall && $urandom_range(3) == 0);
        if (c_idx == stall_idx && stalls < 5) stalls++;
        out_ready = !stall;
        held  = stall;
        h_idx = c_idx; h_re = c_re; h_im = c_im;
        if (!stall) begin
          chk($sformatf("%s/idx_order", tag), c_idx, hs);
          gre[hs] = c_re;
          gim[hs] = c_im;
          hs++;
        end
      end else begin
        out_ready = 1'b0;
        held = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk($sformatf("%s/handshakes", tag), hs, n);
    chk($sformatf("%s/done_pulse", tag), c_dn, 1);
    chk($sformatf("%s/valid_finish", tag), c_ov, 0);
    @(negedge clk);
    chk($sformatf("%s/done_clear", tag), c_dn, 0);
    chk($sformatf("%s/in_ready_back", tag), c_ir, 1);
    chk($sformatf("%s/busy_clear", tag), c_bz, 0);
    chk($sformatf("%s/valid_idle", tag), c_ov, 0);
    chk($sformatf("%s/peak_bin", tag), c_pk, mpk);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s/re[%0d]", tag, k), gre[k], mre[k]);
      chk($sformatf("%s/im[%0d]", tag, k), gim[k], mim[k]);
    end
  endtask

  task automatic run_frame(input int n, input string tag, input int stall_idx, input bit rnd_stall);
    model(n);
    load_frame(n, tag);
    finish_frame(n, tag, stall_idx, rnd_stall);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel8 = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst/in_ready", ir16, 1);
    chk("rst/out_valid", ov16, 0);
    chk("rst/out_idx", idx16, 0);
    chk("rst/out_re", re16, 0);
    chk("rst/out_im", im16, 0);
    chk("rst/done", dn16, 0);
    chk("rst/peak_bin", pk16, 0);
    chk("rst/busy", bz16, 0);
    chk("rst8/in_ready", ir8, 1);
    chk("rst8/out_valid", ov8, 0);
    chk("rst8/busy", bz8, 0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) x[i] = (i == 0) ? 1000 : 0;
    run_frame(16, "impulse", -1, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("impulse/spec_re[%0d]", k), gre[k], 1000);
      chk($sformatf("impulse/spec_im[%0d]", k), gim[k], 0);
    end
`ifdef FFT_PEAK_DETECT_EN
    chk("impulse/spec_peak", c_pk, 1);
`endif

    for (int i = 0; i < 16; i++) x[i] = 100;
    run_frame(16, "dc", -1, 1'b0);
    chk("dc/spec_bin0", gre[0], 1600);
    for (int k = 1; k < 16; k++) chk_rng($sformatf("dc/spec_re[%0d]", k), gre[k], -1, 1);

    for (int i = 0; i < 16; i++) x[i] = int'(rnd(8192.0 * $cos(2.0 * PI * 3.0 * i / 16.0)));
    run_frame(16, "tone", -1, 1'b0);
    chk_rng("tone/spec_bin3", gre[3], 65532, 65540);
    chk_rng("tone/spec_bin13", gre[13], 65532, 65540);
    chk_rng("tone/spec_im3", gim[3], -4, 4);
`ifdef FFT_PEAK_DETECT_EN
    chk("tone/spec_peak", c_pk, 3);
`else
    chk("tone/spec_peak", c_pk, 0);
`endif

    for (int i = 0; i < 16; i++) x[i] = int'($urandom_range(65535)) - 32768;
    run_frame(16, "backpressure", 7, 1'b0);

    for (int i = 0; i < 16; i++) x[i] = int'($urandom_range(65535)) - 32768;
    load_frame(16, "abort");
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort/in_ready", ir16, 1);
    chk("abort/busy", bz16, 0);
    chk("abort/out_valid", ov16, 0);
    for (int i = 0; i < 16; i++) x[i] = (i == 0) ? 1000 : 0;
    run_frame(16, "post_abort", -1, 1'b0);
    chk("post_abort/spec_re5", gre[5], 1000);

    for (int i = 0; i < 8; i++) x[i] = (i % 2 == 0) ? 500 : -500;
    run_frame(8, "n8_alt", -1, 1'b0);
    chk("n8_alt/spec_bin4", gre[4], 4000);
    chk("n8_alt/spec_bin0", gre[0], 0);
`ifdef FFT_PEAK_DETECT_EN
    chk("n8_alt/spec_peak", c_pk, 4);
`endif

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) x[i] = int'($urandom_range(65535)) - 32768;
      run_frame(16, $sformatf("rand16_%0d", f), -1, 1'b1);
    end
    for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(65535)) - 32768;
    run_frame(8, "rand8", -1, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fft_analyzer.md
FFT_ANALYZER -- requirements
Module: fft_analyzer

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning FFT points; legal values are 8, 16 and 32.
REQ-002 The block SHALL have parameter DW, default 16, meaning signed input sample width.
REQ-003 The block SHALL use localparam LOGN = log2(N) and OW = DW+LOGN+1, the output and internal word width.
REQ-004 The block SHALL have reset rst, synchronous, active-high, and clock clk.
REQ-005 The block SHALL have ports as follows (name, direction, width, meaning):
- clk, input, 1, clock.
- rst, input, 1, reset.
- in_valid, input, 1, sample offered.
- in_data, input, DW, signed real sample.
- in_ready, output, 1, block accepts a sample.
- out_valid, output, 1, bin presented.
- out_ready, input, 1, consumer accepts the bin.
- out_idx, output, LOGN, bin index.
- out_re, output, OW, signed real part.
- out_im, output, OW, signed imaginary part.
- done, output, 1, frame-complete pulse.
- peak_bin, output, LOGN, dominant bin.
- busy, output, 1, state is not LOAD.

Function
REQ-006 The FSM SHALL have four states: LOAD, COMPUTE, OUTPUT and FINISH.
REQ-007 In LOAD, in_ready SHALL be 1; each in_valid&&in_ready cycle SHALL store in_data, sign-extended to OW, with im=0, at the bit-reversed address of the sample count.
REQ-008 The Nth accepted sample SHALL move the FSM to COMPUTE on the next edge; in_ready SHALL be 0 in every state other than LOAD.
REQ-009 COMPUTE SHALL run radix-2 DIT with one butterfly per cycle, taking exactly LOGN*N/2 cycles.
REQ-010 Butterfly ordering: stage s = 0..LOGN-1, h = 2^s, p = g*2h+j, q = p+h, and the twiddle is W_N^(j*N/(2h)).
REQ-011 Butterfly result: X[p] = A + W*B and X[q] = A - W*B.
REQ-012 The twiddle ROM SHALL hold 16 entries, W32^k = round(16384*cos(2*pi*k/32)) - j*round(16384*sin(2*pi*k/32)) in Q2.14; N < 32 SHALL index the ROM at k*(32/N).
REQ-013 Each complex product component SHALL be computed at full width, then have 8192 added, then be arithmetic-shifted right by 14 and truncated to OW; the add/subtract SHALL wrap modulo 2^OW.
REQ-014 In OUTPUT, bins SHALL be presented in natural order 0..N-1, with out_valid = 1.
REQ-015 out_idx, out_re and out_im SHALL advance only on out_valid&&out_ready and SHALL be held stable otherwise.
REQ-016 The handshake of bin N-1 SHALL move the FSM to FINISH.
REQ-017 FINISH SHALL last one cycle, during which done = 1 and out_valid = 0; the FSM SHALL then return to LOAD.
REQ-018 Peak detection SHALL compute mag = |re| + |im| over bins 1..N/2 as they are handshaken, keeping the strict maximum so that ties resolve to the lowest index.
REQ-019 peak_bin SHALL update on the FINISH edge and hold until the next FINISH.
REQ-020 busy SHALL be 1 in COMPUTE, OUTPUT and FINISH.
REQ-021 in_valid SHALL be ignored outside LOAD; no sample is lost or buffered.

Reset
REQ-022 While rst is high, at the next edge the FSM SHALL go to LOAD with sample count 0, stage/butterfly counters 0, and the peak tracker cleared.
REQ-023 Reset values SHALL be: in_ready = 1, out_valid = 0, out_idx = 0, out_re = 0, out_im = 0, done = 0, peak_bin = 0, busy = 0.
REQ-024 Reset at any time, including mid-COMPUTE or mid-OUTPUT, SHALL abort the frame; sample memory contents are don't-care and the next frame SHALL be computed correctly.

Configuration
REQ-025 The macro FFT_PEAK_DETECT_EN SHALL control peak detection.
- Defined: the peak tracker and peak_bin SHALL be built per REQ-018 and REQ-019.
- Undefined: no magnitude logic SHALL be built and peak_bin SHALL be constant 0; done and all other behaviour SHALL be unchanged.

Verification
REQ-026 Impulse (N=16): x[0] = 1000, the rest 0 -> every bin re = 1000, im = 0; peak_bin = 1; done pulses once.
REQ-027 DC (N=16): all x = 100 -> bin0 re = 1600; all other bins 0 (+/-1 LSB); peak_bin = 1.
REQ-028 Tone (N=16): x[n] = round(8192*cos(2*pi*3n/16)) -> bins 3 and 13 re = 65536 +/-4, im ~ 0, others ~ 0; peak_bin = 3 (with the macro), 0 (without).
REQ-029 Backpressure: out_ready = 0 for 5 cycles while out_idx = 7 -> out_idx, out_re and out_im hold; bin 8 follows only after out_ready returns to 1; exactly N handshakes occur.
REQ-030 Reset mid-COMPUTE: rst pulsed at cycle 10 of COMPUTE -> next cycle in_ready = 1, busy = 0, out_valid = 0; the following impulse frame matches REQ-026.
REQ-031 N=8: x = +500, -500 alternating -> bin4 re = 4000, others 0; peak_bin = 4; COMPUTE lasts 12 cycles.
